regfile_write_arbiter: RTL and testbench

Shares the single register-file write port of the decode stage between two writeback requesters: requester 0 (vector/scalar ALU) and requester 1 (memory load unit). Each requester has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains one buffered write per cycle into registered write-port outputs. The outputs drive the write-enable, address and data inputs of the decode stage's scalar and vector register files.

---
 rtl/regfile_write_arbiter_if.sv | 45 ++++
 rtl/regfile_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester handshakes and register-file write port of regfile_write_arbiter
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_SIZE   = 6,
    parameter int ADDRESS_WIDTH = 4
);
    localparam int VW = DATA_WIDTH * VECTOR_SIZE;

    logic                     req0Valid;
    logic                     req0Ready;
    logic                     req0IsVector;
    logic [ADDRESS_WIDTH-1:0] req0Address;
    logic [DATA_WIDTH-1:0]    req0ScalarData;
    logic [VW-1:0]            req0VectorData;

    logic                     req1Valid;
    logic                     req1Ready;
    logic                     req1IsVector;
    logic [ADDRESS_WIDTH-1:0] req1Address;
    logic [DATA_WIDTH-1:0]    req1ScalarData;
    logic [VW-1:0]            req1VectorData;

    logic                     writeEnableScalar;
    logic                     writeEnableVector;
    logic [ADDRESS_WIDTH-1:0] writeAddress;
    logic [DATA_WIDTH-1:0]    writeScalarData;
    logic [VW-1:0]            writeVectorData;
    logic                     pending;

    modport master (
        output req0Valid, req0IsVector, req0Address, req0ScalarData, req0VectorData,
        output req1Valid, req1IsVector, req1Address, req1ScalarData, req1VectorData,
        input  req0Ready, req1Ready,
        input  writeEnableScalar, writeEnableVector, writeAddress,
        input  writeScalarData, writeVectorData, pending
    );

    modport slave (
        input  req0Valid, req0IsVector, req0Address, req0ScalarData, req0VectorData,
        input  req1Valid, req1IsVector, req1Address, req1ScalarData, req1VectorData,
        output req0Ready, req1Ready,
        output writeEnableScalar, writeEnableVector, writeAddress,
        output writeScalarData, writeVectorData, pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-entry writeback arbiter onto the shared register-file write port
// WB_ARB_FIXED_PRIORITY_EN: requester 0 wins every contest except same-register ordering.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_SIZE   = 6,
    parameter int ADDRESS_WIDTH = 4
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave wif
);
    localparam int VW = DATA_WIDTH * VECTOR_SIZE;

    logic                     full0_q, full1_q;
    logic                     isv0_q, isv1_q;
    logic [ADDRESS_WIDTH-1:0] addr0_q, addr1_q;
    logic [DATA_WIDTH-1:0]    sd0_q, sd1_q;
    logic [VW-1:0]            vd0_q, vd1_q;
    logic                     older_q;
`ifndef WB_ARB_FIXED_PRIORITY_EN
    logic                     prio_q;
`endif

    logic                     wes_q, wev_q;
    logic [ADDRESS_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0]    wsd_q;
    logic [VW-1:0]            wvd_q;

    logic same_target, contest_pick;
    logic grant0, grant1;
    logic ready0, ready1;
    logic acc0, acc1;
    logic full0_d, full1_d;
    logic older_d;

    always_comb begin
        same_target  = 1'b0;
        contest_pick = 1'b0;
        grant0       = 1'b0;
        grant1       = 1'b0;
        ready0       = 1'b0;
        ready1       = 1'b0;
        acc0         = 1'b0;
        acc1         = 1'b0;
        full0_d      = full0_q;
        full1_d      = full1_q;
        older_d      = older_q;

        // Writes to one register must retire in arrival order regardless of priority.
        same_target = (isv0_q == isv1_q) && (addr0_q == addr1_q);
`ifdef WB_ARB_FIXED_PRIORITY_EN
        contest_pick = same_target ? older_q : 1'b0;
`else
        contest_pick = same_target ? older_q : prio_q;
`endif
        grant0 = full0_q && (!full1_q || !contest_pick);
        grant1 = full1_q && (!full0_q ||  contest_pick);

        ready0 = !full0_q || grant0;
        ready1 = !full1_q || grant1;
        acc0   = wif.req0Valid && ready0;
        acc1   = wif.req1Valid && ready1;

        full0_d = acc0 || (full0_q && !grant0);
        full1_d = acc1 || (full1_q && !grant1);

        // A freshly loaded entry is always the younger one; simultaneous loads favour requester 0.
        if (full0_d && full1_d) begin
            if (acc0 && !acc1)
                older_d = 1'b1;
            else if (acc1)
                older_d = 1'b0;
            else
                older_d = older_q;
        end else if (full1_d) begin
            older_d = 1'b1;
        end else begin
            older_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            isv0_q  <= 1'b0;
            isv1_q  <= 1'b0;
            addr0_q <= '0;
            addr1_q <= '0;
            sd0_q   <= '0;
            sd1_q   <= '0;
            vd0_q   <= '0;
            vd1_q   <= '0;
            older_q <= 1'b0;
`ifndef WB_ARB_FIXED_PRIORITY_EN
            prio_q  <= 1'b0;
`endif
            wes_q   <= 1'b0;
            wev_q   <= 1'b0;
            waddr_q <= '0;
            wsd_q   <= '0;
            wvd_q   <= '0;
        end else begin
            full0_q <= full0_d;
            full1_q <= full1_d;
            older_q <= older_d;

            if (acc0) begin
                isv0_q  <= wif.req0IsVector;
                addr0_q <= wif.req0Address;
                sd0_q   <= wif.req0ScalarData;
                vd0_q   <= wif.req0VectorData;
            end
            if (acc1) begin
                isv1_q  <= wif.req1IsVector;
                addr1_q <= wif.req1Address;
                sd1_q   <= wif.req1ScalarData;
                vd1_q   <= wif.req1VectorData;
            end

`ifndef WB_ARB_FIXED_PRIORITY_EN
            if (grant0)
                prio_q <= 1'b1;
            else if (grant1)
                prio_q <= 1'b0;
`endif

            if (grant0) begin
                wes_q   <= !isv0_q;
                wev_q   <= isv0_q;
                waddr_q <= addr0_q;
                wsd_q   <= sd0_q;
                wvd_q   <= vd0_q;
            end else if (grant1) begin
                wes_q   <= !isv1_q;
                wev_q   <= isv1_q;
                waddr_q <= addr1_q;
                wsd_q   <= sd1_q;
                wvd_q   <= vd1_q;
            end else begin
                wes_q   <= 1'b0;
                wev_q   <= 1'b0;
            end
        end
    end

    assign wif.req0Ready         = ready0;
    assign wif.req1Ready         = ready1;
    assign wif.writeEnableScalar = wes_q;
    assign wif.writeEnableVector = wev_q;
    assign wif.writeAddress      = waddr_q;
    assign wif.writeScalarData   = wsd_q;
    assign wif.writeVectorData   = wvd_q;
    assign wif.pending           = full0_q || full1_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    localparam int DW = 8;
    localparam int VS = 6;
    localparam int AW = 4;
    localparam int VW = DW * VS;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW)) wif ();

    regfile_write_arbiter #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .wif   (wif.slave)
    );

    typedef struct packed {
        logic          ws;
        logic          wv;
        logic [AW-1:0] addr;
        logic [DW-1:0] sd;
        logic [VW-1:0] vd;
    } wr_t;

    typedef struct packed {
        logic          isv;
        logic [AW-1:0] addr;
        logic [DW-1:0] sd;
        logic [VW-1:0] vd;
    } item_t;

    typedef struct {
        logic          req;
        item_t         it;
        logic          ews;
        logic          ewv;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] esd;
        logic [VW-1:0] evd;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    last_wr_cyc = 0;
    wr_t   exp_q[$];
    item_t q0[$];
    item_t q1[$];
    vec_t  tv[6];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expected write.
    always @(negedge clock) begin
        wr_t act;
        wr_t e;
        if (reset && (wif.writeEnableScalar || wif.writeEnableVector)) begin
            last_wr_cyc = cyc;
            act = '{ws: wif.writeEnableScalar, wv: wif.writeEnableVector, addr: wif.writeAddress,
                    sd: wif.writeScalarData, vd: wif.writeVectorData};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h expected=none", 64'(act));
            end else begin
                e = exp_q.pop_front();
                chk("scoreboard_write", 64'(act), 64'(e));
            end
        end
    end

    function automatic item_t mk(input logic isv, input logic [AW-1:0] a,
                                 input logic [DW-1:0] s, input logic [VW-1:0] v);
        item_t it;
        it.isv = isv; it.addr = a; it.sd = s; it.vd = v;
        return it;
    endfunction

    function automatic wr_t exp_of(input item_t it);
        wr_t w;
        w.ws = !it.isv; w.wv = it.isv; w.addr = it.addr; w.sd = it.sd; w.vd = it.vd;
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply0(input item_t it);
        wif.req0Valid = 1'b1; wif.req0IsVector = it.isv; wif.req0Address = it.addr;
        wif.req0ScalarData = it.sd; wif.req0VectorData = it.vd;
    endtask

    task automatic apply1(input item_t it);
        wif.req1Valid = 1'b1; wif.req1IsVector = it.isv; wif.req1Address = it.addr;
        wif.req1ScalarData = it.sd; wif.req1VectorData = it.vd;
    endtask

    task automatic idle();
        wif.req0Valid = 1'b0; wif.req0IsVector = 1'b0; wif.req0Address = '0;
        wif.req0ScalarData = '0; wif.req0VectorData = '0;
        wif.req1Valid = 1'b0; wif.req1IsVector = 1'b0; wif.req1Address = '0;
        wif.req1ScalarData = '0; wif.req1VectorData = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (6) tick();
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_pending"}, 64'(wif.pending), 64'd0);
    endtask

    // Both requesters follow the valid/ready protocol, holding payload until accepted.
    task automatic drive_streams(input int budget);
        int   n;
        logic a0, a1;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            idle();
            if (q0.size() > 0) apply0(q0[0]);
            if (q1.size() > 0) apply1(q1[0]);
            a0 = wif.req0Valid && wif.req0Ready;
            a1 = wif.req1Valid && wif.req1Ready;
            tick();
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            n++;
        end
        idle();
        chk("stream_budget", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    initial begin
        int   start;
        logic rdy;
        item_t a, b;

        tv[0] = '{1'b0, mk(1'b0, 4'd3,  8'h5A, 48'h0), 1'b1, 1'b0, 4'd3,  8'h5A, 48'h0};
        tv[1] = '{1'b1, mk(1'b1, 4'd4,  8'h00, 48'h060504030201), 1'b0, 1'b1, 4'd4, 8'h00, 48'h060504030201};
        tv[2] = '{1'b0, mk(1'b1, 4'd15, 8'h11, 48'hA5A5A5A5A5A5), 1'b0, 1'b1, 4'd15, 8'h11, 48'hA5A5A5A5A5A5};
        tv[3] = '{1'b1, mk(1'b0, 4'd0,  8'hFF, 48'h0), 1'b1, 1'b0, 4'd0,  8'hFF, 48'h0};
        tv[4] = '{1'b1, mk(1'b0, 4'd9,  8'h3C, 48'h123456789ABC), 1'b1, 1'b0, 4'd9, 8'h3C, 48'h123456789ABC};
        tv[5] = '{1'b0, mk(1'b1, 4'd0,  8'hC3, 48'hFFFFFFFFFFFF), 1'b0, 1'b1, 4'd0, 8'hC3, 48'hFFFFFFFFFFFF};

        idle();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_wes",     64'(wif.writeEnableScalar), 64'd0);
        chk("rst_wev",     64'(wif.writeEnableVector), 64'd0);
        chk("rst_addr",    64'(wif.writeAddress),      64'd0);
        chk("rst_sdata",   64'(wif.writeScalarData),   64'd0);
        chk("rst_vdata",   64'(wif.writeVectorData),   64'd0);
        chk("rst_pending", 64'(wif.pending),           64'd0);
        chk("rst_ready0",  64'(wif.req0Ready),         64'd1);
        chk("rst_ready1",  64'(wif.req1Ready),         64'd1);
        reset = 1'b1;

        // Single uncontested writes: strobe exactly one cycle after the accepting edge.
        for (int i = 0; i < 6; i++) begin
            if (tv[i].req) apply1(tv[i].it); else apply0(tv[i].it);
            rdy = tv[i].req ? wif.req1Ready : wif.req0Ready;
            chk("tv_ready", 64'(rdy), 64'd1);
            exp_q.push_back('{ws: tv[i].ews, wv: tv[i].ewv, addr: tv[i].eaddr, sd: tv[i].esd, vd: tv[i].evd});
            tick();
            idle();
            chk("tv_pending_after_accept", 64'(wif.pending), 64'd1);
            chk("tv_no_early_strobe", 64'({wif.writeEnableScalar, wif.writeEnableVector}), 64'd0);
            tick();
            chk("tv_wes",   64'(wif.writeEnableScalar), 64'(tv[i].ews));
            chk("tv_wev",   64'(wif.writeEnableVector), 64'(tv[i].ewv));
            chk("tv_addr",  64'(wif.writeAddress),      64'(tv[i].eaddr));
            chk("tv_sdata", 64'(wif.writeScalarData),   64'(tv[i].esd));
            chk("tv_vdata", 64'(wif.writeVectorData),   64'(tv[i].evd));
            chk("tv_pending_cleared", 64'(wif.pending), 64'd0);
        end
        drain("table");

        // Two saturating requesters with distinct targets.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 4'd1, 8'(8'h10 + i), 48'h0));
            q1.push_back(mk(1'b0, 4'd2, 8'(8'h20 + i), 48'h0));
        end
`ifdef WB_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_of(q0[i]));
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_of(q1[i]));
`else
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_of(q0[i]));
            exp_q.push_back(exp_of(q1[i]));
        end
`endif
        start = cyc + 1;
        drive_streams(40);
        drain("alternate");
        chk("alternate_last_write_edge", 64'(last_wr_cyc - start), 64'd8);

        // req1 accepted one cycle before req0, same vector register.
        do_reset();
        a = mk(1'b1, 4'd4, 8'hA0, 48'hAAAAAAAAAA01);
        b = mk(1'b1, 4'd4, 8'hB1, 48'hBBBBBBBBBB02);
        apply1(b);
        exp_q.push_back(exp_of(b));
        tick();
        idle();
        apply0(a);
        exp_q.push_back(exp_of(a));
        tick();
        idle();
        drain("same_reg_staggered");

        // Simultaneous same-register writes while prio points at requester 1: requester 0 is older.
        do_reset();
        q0.push_back(mk(1'b0, 4'd5, 8'h55, 48'h0));
        exp_q.push_back(exp_of(q0[0]));
        drive_streams(10);
        drain("prio_setup_a");
        a = mk(1'b1, 4'd4, 8'h0A, 48'h00000000000A);
        b = mk(1'b1, 4'd4, 8'h0B, 48'h00000000000B);
        q0.push_back(a);
        q1.push_back(b);
        exp_q.push_back(exp_of(a));
        exp_q.push_back(exp_of(b));
        drive_streams(10);
        drain("same_reg_simultaneous");

        // Distinct targets while prio points at requester 1.
        do_reset();
        q0.push_back(mk(1'b0, 4'd5, 8'h55, 48'h0));
        exp_q.push_back(exp_of(q0[0]));
        drive_streams(10);
        drain("prio_setup_b");
        a = mk(1'b0, 4'd6, 8'hC6, 48'h0);
        b = mk(1'b0, 4'd7, 8'hD7, 48'h0);
        q0.push_back(a);
        q1.push_back(b);
`ifdef WB_ARB_FIXED_PRIORITY_EN
        exp_q.push_back(exp_of(a));
        exp_q.push_back(exp_of(b));
`else
        exp_q.push_back(exp_of(b));
        exp_q.push_back(exp_of(a));
`endif
        drive_streams(10);
        drain("prio_contest");

        // Lone requester streaming back-to-back.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a = mk(1'b0, 4'(i), 8'(8'h30 + i), 48'h0);
            apply0(a);
            chk("stream_ready0", 64'(wif.req0Ready), 64'd1);
            exp_q.push_back(exp_of(a));
            tick();
            if (i > 0) chk("stream_strobe", 64'(wif.writeEnableScalar), 64'd1);
        end
        idle();
        tick();
        chk("stream_last_strobe", 64'(wif.writeEnableScalar), 64'd1);
        chk("stream_last_addr",   64'(wif.writeAddress),      64'd5);
        tick();
        chk("stream_strobe_off",  64'(wif.writeEnableScalar), 64'd0);
        drain("stream");

        // Reset with both holding buffers full drops the buffered writes.
        do_reset();
        apply0(mk(1'b0, 4'd1, 8'h61, 48'h0));
        apply1(mk(1'b0, 4'd2, 8'h62, 48'h0));
        tick();
        idle();
        chk("midrst_pending_before", 64'(wif.pending), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_ready0",  64'(wif.req0Ready), 64'd1);
        chk("midrst_ready1",  64'(wif.req1Ready), 64'd1);
        chk("midrst_pending", 64'(wif.pending),   64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_strobe", 64'({wif.writeEnableScalar, wif.writeEnableVector}), 64'd0);
        end
        drain("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
